// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the CPU cache port, the VGA fetch port and the SDRAM controller
// command/read port handled by sdram_port_arbiter.
//
// Handshake rules, all in the sdram_clk domain:
//   - cpu_req / vga_req are levels held by the master until its one-cycle ack.
//   - mem_ren / mem_wen fire for exactly one cycle, and only in a cycle where
//     mem_ready is high. mem_addr/mem_len/mem_mask/mem_wdata stay stable from
//     the cycle before the command until the burst ends.
//   - Read words arrive on mem_rdata qualified by mem_rvalid. mem_done pulses
//     once to end the burst and may coincide with the last mem_rvalid.
interface sdram_port_arbiter_if;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [3:0]   cpu_len;
    logic [3:0]   cpu_mask;
    logic [511:0] cpu_wdata;
    logic [511:0] cpu_rdata;
    logic         cpu_ack;

    logic         vga_req;
    logic [31:0]  vga_addr;
    logic [31:0]  vga_rdata;
    logic         vga_rvalid;
    logic         vga_ack;

    logic         mem_ren;
    logic         mem_wen;
    logic [31:0]  mem_addr;
    logic [7:0]   mem_len;
    logic [3:0]   mem_mask;
    logic [511:0] mem_wdata;
    logic         mem_ready;
    logic [31:0]  mem_rdata;
    logic         mem_rvalid;
    logic         mem_done;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_len, cpu_mask, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  vga_req, vga_addr,
        output vga_rdata, vga_rvalid, vga_ack,
        output mem_ren, mem_wen, mem_addr, mem_len, mem_mask, mem_wdata,
        input  mem_ready, mem_rdata, mem_rvalid, mem_done
    );

    // Masters and controller side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_len, cpu_mask, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output vga_req, vga_addr,
        input  vga_rdata, vga_rvalid, vga_ack,
        input  mem_ren, mem_wen, mem_addr, mem_len, mem_mask, mem_wdata,
        output mem_ready, mem_rdata, mem_rvalid, mem_done
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller request port between the CPU cache line port
// and the VGA framebuffer fetcher. VGA has priority, limited by a streak
// counter so a pending CPU request is served after VGA_MAX_STREAK VGA bursts.
// CPU read words are packed into a 512-bit line; VGA words stream through
// with one cycle of latency. A burst without mem_done for DONE_TIMEOUT cycles
// is abandoned and still acknowledged.
// Optional: define SDRAM_ARB_STATS_EN to add grant/wait/timeout statistics.
module sdram_port_arbiter #(
    parameter int VGA_MAX_STREAK = 4,
    parameter int VGA_BURST_LEN  = 15,
    parameter int DONE_TIMEOUT   = 1023
) (
    input  logic                  sdram_clk,
    input  logic                  reset,
    sdram_port_arbiter_if.slave   bus,
    output logic [1:0]            dbg_state,
    output logic                  dbg_abort
`ifdef SDRAM_ARB_STATS_EN
    ,
    output logic [31:0]           stat_vga_grants,
    output logic [31:0]           stat_cpu_grants,
    output logic [15:0]           stat_cpu_wait_max,
    output logic [15:0]           stat_timeouts
`endif
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int SW = $clog2(VGA_MAX_STREAK + 1);
    localparam int TW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX   = SW'(VGA_MAX_STREAK);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(DONE_TIMEOUT - 1);

    state_t         state, state_nxt;
    logic           grant_vga, is_write, abort;
    logic [3:0]     cpu_len_q;
    logic [SW-1:0]  streak;
    logic [4:0]     word_cnt;
    logic [TW-1:0]  tmo_cnt;
    logic [31:0]    mem_addr_q, vga_rdata_q;
    logic [7:0]     mem_len_q;
    logic [3:0]     mem_mask_q;
    logic [511:0]   mem_wdata_q, cpu_rdata_q;
    logic           vga_rvalid_q, mem_ren_c, mem_wen_c;

    logic cpu_wins, grant_fire, timed_out, timeout_fire, vga_busy, cpu_capture;

    // CPU wins only when VGA is idle or VGA has used up its streak.
    assign cpu_wins     = bus.cpu_req && (!bus.vga_req || streak == STREAK_MAX);
    assign grant_fire   = (state == S_IDLE) && (bus.cpu_req || bus.vga_req);
    assign timed_out    = (tmo_cnt == TIMEOUT_LAST);
    // A mem_done arriving on the last timeout cycle is a normal completion.
    assign timeout_fire = timed_out && ((state == S_ISSUE) ||
                                        (state == S_BUSY && !bus.mem_done));
    assign vga_busy     = (state == S_BUSY) && grant_vga;
    assign cpu_capture  = (state == S_BUSY) && !grant_vga && !is_write && bus.mem_rvalid;

    // State register
    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state and the one-cycle command strobes
    always_comb begin
        state_nxt = state;
        mem_ren_c = 1'b0;
        mem_wen_c = 1'b0;
        case (state)
            S_IDLE:  if (grant_fire) state_nxt = S_ISSUE;
            S_ISSUE: begin
                // Timeout wins so the counter can never run past its limit.
                if (timed_out) begin
                    state_nxt = S_DONE;
                end else if (bus.mem_ready) begin
                    state_nxt = S_BUSY;
                    mem_ren_c = !is_write;
                    mem_wen_c = is_write;
                end
            end
            S_BUSY:  if (bus.mem_done || timed_out) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Timeout counter runs while a command is issuing or in flight
    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset)                                     tmo_cnt <= '0;
        else if (state == S_ISSUE || state == S_BUSY)  tmo_cnt <= tmo_cnt + 1'b1;
        else                                           tmo_cnt <= '0;
    end

    // Latch the winner's command fields and update the VGA streak at grant
    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset) begin
            grant_vga   <= 1'b0;
            is_write    <= 1'b0;
            cpu_len_q   <= '0;
            streak      <= '0;
            mem_addr_q  <= '0;
            mem_len_q   <= '0;
            mem_mask_q  <= '0;
            mem_wdata_q <= '0;
        end else if (grant_fire) begin
            grant_vga <= !cpu_wins;
            if (cpu_wins) begin
                is_write    <= bus.cpu_we;
                cpu_len_q   <= bus.cpu_len;
                streak      <= '0;
                mem_addr_q  <= bus.cpu_addr;
                mem_len_q   <= {4'b0, bus.cpu_len};
                mem_mask_q  <= bus.cpu_mask;
                mem_wdata_q <= bus.cpu_wdata;
            end else begin
                is_write    <= 1'b0;
                mem_addr_q  <= bus.vga_addr;
                mem_len_q   <= 8'(VGA_BURST_LEN);
                mem_mask_q  <= 4'hF;
                mem_wdata_q <= '0;
                if (bus.cpu_req && streak != STREAK_MAX) streak <= streak + 1'b1;
            end
        end
    end

    // Pack CPU read words into the line; words past cpu_len are dropped
    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset) begin
            cpu_rdata_q <= '0;
            word_cnt    <= '0;
        end else if (grant_fire) begin
            word_cnt <= '0;
            if (cpu_wins) cpu_rdata_q <= '0;
        end else if (cpu_capture) begin
            if (word_cnt <= {1'b0, cpu_len_q})
                cpu_rdata_q[{word_cnt[3:0], 5'd0} +: 32] <= bus.mem_rdata;
            if (word_cnt != 5'd16) word_cnt <= word_cnt + 1'b1;
        end
    end

    // Abort flag marks a burst that ended by timeout; kept until next grant
    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset)             abort <= 1'b0;
        else if (grant_fire)   abort <= 1'b0;
        else if (timeout_fire) abort <= 1'b1;
    end

    // Registered pass-through of read words during a VGA burst
    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset) begin
            vga_rvalid_q <= 1'b0;
            vga_rdata_q  <= '0;
        end else begin
            vga_rvalid_q <= vga_busy && bus.mem_rvalid;
            if (vga_busy && bus.mem_rvalid) vga_rdata_q <= bus.mem_rdata;
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    logic [15:0] cpu_wait_cnt;
    logic        cpu_in_service;
    assign cpu_in_service = (state != S_IDLE) && !grant_vga;

    // Grant, wait and timeout statistics
    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset) begin
            stat_vga_grants   <= '0;
            stat_cpu_grants   <= '0;
            stat_cpu_wait_max <= '0;
            stat_timeouts     <= '0;
            cpu_wait_cnt      <= '0;
        end else begin
            if (grant_fire && !cpu_wins) stat_vga_grants <= stat_vga_grants + 1'b1;
            if (grant_fire && cpu_wins) begin
                stat_cpu_grants <= stat_cpu_grants + 1'b1;
                if (cpu_wait_cnt > stat_cpu_wait_max) stat_cpu_wait_max <= cpu_wait_cnt;
                cpu_wait_cnt <= '0;
            end else if (!bus.cpu_req) begin
                cpu_wait_cnt <= '0;
            end else if (!cpu_in_service && cpu_wait_cnt != 16'hFFFF) begin
                cpu_wait_cnt <= cpu_wait_cnt + 1'b1;
            end
            if (timeout_fire) stat_timeouts <= stat_timeouts + 1'b1;
        end
    end
`endif

    assign bus.mem_ren    = mem_ren_c;
    assign bus.mem_wen    = mem_wen_c;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_len    = mem_len_q;
    assign bus.mem_mask   = mem_mask_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_ack    = (state == S_DONE) && !grant_vga;
    assign bus.vga_ack    = (state == S_DONE) && grant_vga;
    assign bus.vga_rdata  = vga_rdata_q;
    assign bus.vga_rvalid = vga_rvalid_q;
    assign dbg_state      = state;
    assign dbg_abort      = abort;
endmodule
